// File: rtl/tmax_tracker.sv
// ----------------------------------------------------------------------------
// tmax_tracker
//   Multi-channel running max/min tracker with position capture. One sample
//   stream is compared against the channel picked by NUMBER (1-based). An
//   accepted sample is held in a single stage-1 register and then committed
//   to the per-channel store. A sample on the same channel in the next cycle
//   compares against the forwarded stage-1 value, so back-to-back samples
//   give the same result as sequential processing.
//
// Ports
//   CLK, RESET_N        clock, async active-low reset
//   T[DW]               unsigned sample
//   EN                  sample valid
//   SOL                 start of line, restarts the position counter
//   NUMBER[5]           1-based channel select (0 or >NCH: none)
//   EN_CPU[NCH]         per-channel write/clear enable
//   CLR                 sync clear of the enabled channels
//   MODE                0 = track max, 1 = track min
//   Tout[DW], POS[PW]   committed extremum/position of the selected channel
//   VLD                 selected channel holds an accepted sample
//   UPD                 one-cycle pulse: stage 1 holds an accepted update
// ----------------------------------------------------------------------------

// Per-channel store. A clear beats a pending write landing on the same edge.
module tmax_chan #(
    parameter int DW = 10,
    parameter int PW = 11
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          clr,
    input  logic          wr,
    input  logic [DW-1:0] wval,
    input  logic [PW-1:0] wpos,
    output logic [DW-1:0] val,
    output logic [PW-1:0] pos,
    output logic          seen
);
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            val  <= '0;
            pos  <= '0;
            seen <= 1'b0;
        end else if (clr) begin
            val  <= '0;
            pos  <= '0;
            seen <= 1'b0;
        end else if (wr) begin
            val  <= wval;
            pos  <= wpos;
            seen <= 1'b1;
        end
    end
endmodule

module tmax_tracker #(
    parameter int DW  = 10,
    parameter int NCH = 20,
    parameter int PW  = 11
) (
    input  logic           CLK,
    input  logic           RESET_N,
    input  logic [DW-1:0]  T,
    input  logic           EN,
    input  logic           SOL,
    input  logic [4:0]     NUMBER,
    input  logic [NCH-1:0] EN_CPU,
    input  logic           CLR,
    input  logic           MODE,
    output logic [DW-1:0]  Tout,
    output logic [PW-1:0]  POS,
    output logic           VLD,
    output logic           UPD
);
    typedef struct packed {
        logic          acc;
        logic [4:0]    num;
        logic [DW-1:0] val;
        logic [PW-1:0] pos;
    } s1_t;

    s1_t s1, s1_d;

    logic [PW-1:0] pc, tag;
    logic [NCH-1:0] hit;
    logic [NCH-1:0][DW-1:0] ch_val;
    logic [NCH-1:0][PW-1:0] ch_pos;
    logic [NCH-1:0]         ch_seen;

    logic [DW-1:0] rd_val, eff_val;
    logic [PW-1:0] rd_pos;
    logic          rd_seen, eff_seen, fwd, elig;

    // Position counter. A sample arriving with SOL takes position 0, so the
    // counter moves on to 1 for the next sample. Saturates at all-ones.
    assign tag = SOL ? '0 : pc;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            pc <= '0;
        else if (SOL)
            pc <= EN ? PW'(1) : '0;
        else if (EN && (pc != '1))
            pc <= pc + PW'(1);
    end

    // Channel array; hit[] is the one-hot decode of NUMBER (all zero when
    // NUMBER is 0 or out of range).
    for (genvar j = 0; j < NCH; j++) begin : g_ch
        assign hit[j] = (NUMBER == 5'(j + 1));

        tmax_chan #(.DW(DW), .PW(PW)) u_ch (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .clr     (CLR && EN_CPU[j]),
            .wr      (s1.acc && (s1.num == 5'(j + 1))),
            .wval    (s1.val),
            .wpos    (s1.pos),
            .val     (ch_val[j]),
            .pos     (ch_pos[j]),
            .seen    (ch_seen[j])
        );
    end

    // Committed read of the selected channel; zero when none is selected.
    always_comb begin
        rd_val  = '0;
        rd_pos  = '0;
        rd_seen = 1'b0;
        for (int j = 0; j < NCH; j++) begin
            if (hit[j]) begin
                rd_val  = ch_val[j];
                rd_pos  = ch_pos[j];
                rd_seen = ch_seen[j];
            end
        end
    end

    // Stage 0: compare against the pending stage-1 value when it targets the
    // same channel, otherwise against the committed store.
    assign elig     = EN && |(hit & EN_CPU) && !CLR;
    assign fwd      = s1.acc && (s1.num == NUMBER);
    assign eff_val  = fwd ? s1.val : rd_val;
    assign eff_seen = fwd | rd_seen;

    always_comb begin
        s1_d     = '0;
        s1_d.num = NUMBER;
        s1_d.val = T;
        s1_d.pos = tag;
        s1_d.acc = elig && (!eff_seen ||
                            (!MODE && (T > eff_val)) ||
                            ( MODE && (T < eff_val)));
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            s1 <= '0;
        else
            s1 <= s1_d;
    end

    assign Tout = rd_val;
    assign POS  = rd_pos;
    assign VLD  = rd_seen;
    assign UPD  = s1.acc;
endmodule
